ysyx_23060201_mem_arb: RTL
==========================

YSYX_23060201_MEM_ARB -- requirements
Module: ysyx_23060201_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; mask width is DATA_WIDTH/8.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 ifu_req_valid  in  1  fetch request pending.
REQ-007 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-008 ifu_addr  in  ADDR_WIDTH  fetch address (pc).
REQ-009 ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid.
REQ-010 ifu_rdata  out  DATA_WIDTH  fetched instruction.
REQ-011 lsu_req_valid  in  1  load/store request pending.
REQ-012 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-013 lsu_addr  in  ADDR_WIDTH  load/store address.
REQ-014 lsu_wen  in  1  1 = store, 0 = load.
REQ-015 lsu_wdata / lsu_wmask  in  DATA_WIDTH / DATA_WIDTH/8  store data and byte mask.
REQ-016 lsu_resp_valid / lsu_rdata  out  1 / DATA_WIDTH  completion pulse and load data (store: rdata don't-care).
REQ-017 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-018 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  registered request fields.
REQ-019 mem_resp_valid / mem_rdata  in  1 / DATA_WIDTH  memory response; requesters always accept responses.

Function
REQ-020 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE, one transaction outstanding at a time.
REQ-021 In IDLE with any req_valid, SHALL assert exactly one req_ready (the grantee) combinationally, latch its addr/wen/wdata/wmask plus owner id, and enter REQ next cycle.
REQ-022 IFU grant SHALL force mem_wen=0 and mem_wmask=all-ones.
REQ-023 In REQ, mem_req_valid SHALL be 1 with stable fields until mem_req_ready=1; then enter WAIT.
REQ-024 In WAIT, on mem_resp_valid=1: owner's resp_valid=1 in the same cycle, rdata = mem_rdata (combinational), FSM returns to IDLE.
REQ-025 Non-owner resp_valid SHALL be 0; mem_resp_valid outside WAIT SHALL be ignored.
REQ-026 req_ready SHALL be 0 in REQ and WAIT; a new grant is possible in the cycle after the response (IDLE).
REQ-027 Minimum latency: accept at N, mem_req_valid at N+1, response no earlier than N+2.
REQ-028 Single-requester case SHALL grant that requester regardless of arbitration history.

Reset
REQ-029 On rst: state=IDLE, owner=none, last_grant=LSU; all req_ready, resp_valid and mem_req_valid are 0 in the cycle after rst.
REQ-030 Reset mid-REQ/WAIT SHALL abandon the transaction with no response pulse; a late mem_resp_valid SHALL be ignored.

Configuration
REQ-031 Macro YSYX_23060201_ARB_RR_EN defined: tie -> grant the requester not in last_grant; last_grant updates on every grant.
REQ-032 Macro undefined: tie -> fixed priority, LSU wins; last_grant register is absent.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding (IDLE/REQ/WAIT) and owner ids (OWN_NONE, OWN_IFU, OWN_LSU).
REQ-034 SHALL instantiate one sub-module ysyx_23060201_arb_pick (2-way priority/round-robin picker, combinational); FSM and latches stay in top.

Verification
REQ-035 IFU only, addr=0x80000000, memory ready=1, 2-cycle latency -> ifu_req_ready at N, mem_req_valid at N+1, ifu_resp_valid at N+3 with mem_rdata passed through.
REQ-036 Both valid in IDLE after reset (RR_EN) -> IFU granted first, then LSU, then IFU (alternating); without RR_EN -> LSU every tie.
REQ-037 LSU store addr=0x80000100, wdata=0xDEADBEEF, wmask=0x3 -> mem_wen=1, fields held stable across 3 cycles of mem_req_ready=0.
REQ-038 rst pulsed during WAIT, then mem_resp_valid=1 -> no resp_valid pulse; next IFU request completes normally.
REQ-039 Spurious mem_resp_valid in IDLE -> ifu_resp_valid=lsu_resp_valid=0, state unchanged.

Source files
------------

// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// rtl/ysyx_23060201_mem_arb_pkg.sv - shared FSM state and owner encodings for the memory arbiter
package ysyx_23060201_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

endpackage

// File: rtl/ysyx_23060201_arb_pick.sv
// rtl/ysyx_23060201_arb_pick.sv - combinational 2-way picker between fetch and load/store
// Ports:
//   ifu_valid, lsu_valid : pending requests
//   prefer_ifu           : tie-break hint, 1 = IFU wins a tie, 0 = LSU wins a tie
//   grant                : chosen owner, OWN_NONE when nothing is pending
module ysyx_23060201_arb_pick
  import ysyx_23060201_mem_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  logic   prefer_ifu,
  output owner_t grant
);

  // A lone requester always wins; the hint only matters on a tie.
  always_comb begin
    grant = OWN_NONE;
    if (ifu_valid && lsu_valid) begin
      grant = prefer_ifu ? OWN_IFU : OWN_LSU;
    end else if (ifu_valid) begin
      grant = OWN_IFU;
    end else if (lsu_valid) begin
      grant = OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// rtl/ysyx_23060201_mem_arb.sv - single-outstanding arbiter of IFU and LSU onto one memory port
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr      : fetch request handshake
//   ifu_resp_valid, ifu_rdata          : fetch completion pulse and data
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask      : load/store request handshake
//   lsu_resp_valid, lsu_rdata          : load/store completion pulse and data
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask      : registered memory request
//   mem_resp_valid, mem_rdata          : memory response
// Build option: YSYX_23060201_ARB_RR_EN selects round-robin tie-break; otherwise LSU wins ties.
module ysyx_23060201_mem_arb
  import ysyx_23060201_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  owner_t     grant;
  logic       prefer_ifu;
  logic       accept;
  logic       resp_fire;

`ifdef YSYX_23060201_ARB_RR_EN
  owner_t last_grant_q;
  // Give a tie to whoever did not win the previous grant.
  assign prefer_ifu = (last_grant_q == OWN_LSU);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_LSU;
    end else if (accept) begin
      last_grant_q <= grant;
    end
  end
`else
  assign prefer_ifu = 1'b0;
`endif

  ysyx_23060201_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .prefer_ifu (prefer_ifu),
    .grant      (grant)
  );

  assign accept    = (state_q == ST_IDLE) && (grant != OWN_NONE);
  // Responses only count while a transaction is waiting; anything else is stale.
  assign resp_fire = (state_q == ST_WAIT) && mem_resp_valid;

  always_comb begin
    state_d        = state_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = mem_rdata;
    lsu_rdata      = mem_rdata;
    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = accept && (grant == OWN_IFU);
        lsu_req_ready = accept && (grant == OWN_LSU);
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
        lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
        if (resp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant;
      end else if (resp_fire) begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Request fields are captured at grant so the requester may move on immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (accept) begin
      if (grant == OWN_IFU) begin
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '1;
      end else begin
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
      end
    end
  end

endmodule
